linreg_ctrl: RTL and testbench
==============================

Name: linreg_ctrl

Overview:
- Sequencing FSM for the linear-regression accumulator datapath. The datapath computes sum x, sum y, sum xx and sum xy, then b0 and b1.
- Accepts a valid/ready sample stream and clears the four accumulators at run start.
- Issues ldx/ldy, then ldsum* per sample, counts samples, and waits a fixed settle time for the combinational divide path before flagging the results valid.
- Sits between the sample source (memory or streaming front end) and the datapath; the top level wires x/y straight to the datapath.

Parameters:
- N_SAMPLES, 150: samples per run; the datapath's /150 constants must match.
- CNT_W, 9: width of the sample counter; must satisfy 2**CNT_W > N_SAMPLES.
- SETTLE_CYCLES, 4: wait cycles after the last accumulate before done, covering the multicycle divide path; minimum 1.
- TIMEOUT_CYCLES, 1024: starvation limit, used only with the optional feature.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin a run; sampled in IDLE or DONE
- abort  in  1  synchronous return to IDLE
- in_valid  in  1  source has x/y on the datapath inputs
- in_ready  out  1  controller accepts a sample this cycle
- ldx, ldy  out  1  load datapath x/y registers
- initsumx, initsumy, initsumxx, initsumxy  out  1  clear accumulators
- ldsumx, ldsumy, ldsumxx, ldsumxy  out  1  accumulate
- count  out  CNT_W  samples accumulated in the current run
- en  out  1  b0/b1 valid (high in DONE)
- busy  out  1  high in INIT, WAIT, ACCUM and SETTLE
- err  out  1  timeout error (feature only, else constant 0)

Behaviour:
- Reset: the FSM goes to IDLE and every output is 0, including count. Reset is asynchronous and applies mid-run; no partial state survives.
- States: IDLE, INIT, WAIT, ACCUM, SETTLE, DONE, plus ERR with the feature.
- IDLE: start -> INIT.
- INIT (1 cycle):
  - All four initsum* are high and count clears to 0.
  - Next state is WAIT.
- WAIT:
  - in_ready = 1.
  - ldx = ldy = in_valid & in_ready, in the same cycle, so the datapath captures x/y on that edge.
  - Handshake -> ACCUM. With no handshake the FSM stays in WAIT.
- ACCUM (1 cycle):
  - All four ldsum* are high and count increments.
  - If count == N_SAMPLES-1 before the increment -> SETTLE, else -> WAIT.
- SETTLE:
  - An internal counter runs for SETTLE_CYCLES cycles, then the FSM goes to DONE.
  - The settle counter is separate from count.
- DONE:
  - en = 1; count holds N_SAMPLES.
  - The FSM stays in DONE until start, then goes to INIT (back-to-back runs). It never returns to IDLE on its own.
- Outputs: all outputs are pure decodes of state, except ldx/ldy, which are Mealy on in_valid. in_ready never depends combinationally on in_valid.
- start while busy is ignored.
- abort has priority over every transition: next state is IDLE and count clears. Accumulator contents are left as-is and are cleared by the next INIT.
- abort and start in the same IDLE cycle: abort wins, and the FSM stays in IDLE.
- Latency with in_valid held high and start sampled at edge E:
  - sample k is in ACCUM after edge E+2+2k;
  - en rises after edge E+2*N_SAMPLES+1+SETTLE_CYCLES, which is E+305 at the defaults.
- Throughput is one sample per 2 cycles at most.
- count never wraps; it saturates at N_SAMPLES by construction.

Optional Feature:
- Macro: LINREG_CTRL_TIMEOUT_EN.
- Enabled:
  - A watchdog counts consecutive WAIT cycles without a handshake.
  - On reaching TIMEOUT_CYCLES the FSM goes to ERR: err = 1, busy = 0, all load strobes 0.
  - From ERR, start -> INIT (and err clears); abort -> IDLE.
  - The watchdog clears on every handshake and on leaving WAIT.
- Disabled: there is no watchdog and no ERR state, WAIT stalls indefinitely, and err is tied to 0.

Decomposition:
- Package linreg_pkg holds:
  - the state enum type (linreg_state_t);
  - default constants: LINREG_N_SAMPLES = 150 and LINREG_CNT_W = 9, shared with the datapath divisor.
- The watchdog is a natural sub-module, linreg_watchdog, instantiated only under the macro. Its interface is clk, rst, clr, tick, and expired.
- The FSM and counters stay in linreg_ctrl.

Test Plan:
- Reset: assert rst mid-ACCUM -> all outputs 0 asynchronously, before the next edge; state is IDLE and count = 0.
- Nominal run (N_SAMPLES=4, SETTLE_CYCLES=2, in_valid held 1):
  - start at edge E -> initsum* high for one cycle;
  - ldx/ldy at cycles E+1, 3, 5, 7 and ldsum* at E+2, 4, 6, 8;
  - en high from E+11 with count = 4.
- Backpressure: drop in_valid for 5 cycles after the 2nd sample -> in_ready stays high, no ldx/ldy/ldsum*, count holds 2, and the run completes 5 cycles late.
- abort in SETTLE -> IDLE next cycle, en never rises, count = 0. A subsequent start produces a full, clean run.
- Back-to-back: start in DONE -> INIT next cycle, en drops, and the second run gives identical timing. start during WAIT is ignored.
- Timeout (macro on, TIMEOUT_CYCLES=8): hold in_valid low in WAIT -> err rises after 8 cycles. Then start -> INIT and err clears.

Source files
------------

// File: rtl/linreg_pkg.sv
// Shared types and default sizing for the linear-regression controller and datapath.
// The datapath's /N divisor constants must track LINREG_N_SAMPLES.
package linreg_pkg;

  localparam int LINREG_N_SAMPLES = 150;
  localparam int LINREG_CNT_W     = 9;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_WAIT,
    ST_ACCUM,
    ST_SETTLE,
    ST_DONE,
    ST_ERR
  } linreg_state_t;

endpackage

// File: rtl/linreg_watchdog.sv
// Starvation watchdog: down-counter reloaded on clr, expires on the TIMEOUT_CYCLES-th tick.
// Only instantiated when LINREG_CTRL_TIMEOUT_EN is defined.
module linreg_watchdog #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic tick,
  output logic expired
);

  localparam int W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [W-1:0] LOAD = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= LOAD;
    else if (clr)
      cnt <= LOAD;
    else if (tick && (cnt != '0))
      cnt <= cnt - W'(1);
  end

  // Expires combinationally on the terminal tick so the FSM leaves WAIT on that same edge.
  assign expired = tick && (cnt == '0);

endmodule

// File: rtl/linreg_ctrl.sv
// Sequencing FSM for the linear-regression accumulator datapath.
// Optional starvation watchdog / ERR state: define LINREG_CTRL_TIMEOUT_EN.
//
// state  | meaning
// IDLE   | waiting for start after reset or abort
// INIT   | clear the four accumulators, count -> 0
// WAIT   | in_ready high; handshake loads x/y
// ACCUM  | accumulate captured sample, count + 1
// SETTLE | let the multicycle divide path settle
// DONE   | b0/b1 valid; start launches the next run
// ERR    | watchdog starvation (feature builds only)
module linreg_ctrl
  import linreg_pkg::*;
#(
  parameter int N_SAMPLES      = LINREG_N_SAMPLES,
  parameter int CNT_W          = LINREG_CNT_W,
  parameter int SETTLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             ldx,
  output logic             ldy,
  output logic             initsumx,
  output logic             initsumy,
  output logic             initsumxx,
  output logic             initsumxy,
  output logic             ldsumx,
  output logic             ldsumy,
  output logic             ldsumxx,
  output logic             ldsumxy,
  output logic [CNT_W-1:0] count,
  output logic             en,
  output logic             busy,
  output logic             err
);

  localparam int SET_W = $clog2(SETTLE_CYCLES) + 1;
  localparam logic [SET_W-1:0] SETTLE_LOAD = SET_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LAST_IDX    = CNT_W'(N_SAMPLES - 1);

  linreg_state_t state, state_nx;
  logic [SET_W-1:0] settle_cnt;
  logic hs;
  logic wd_expired;

  assign hs = (state == ST_WAIT) && in_valid;

`ifdef LINREG_CTRL_TIMEOUT_EN
  linreg_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clr     ((state != ST_WAIT) || hs),
    .tick    ((state == ST_WAIT) && !hs),
    .expired (wd_expired)
  );
`else
  assign wd_expired = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= ST_IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:   if (start) state_nx = ST_INIT;
      ST_INIT:   state_nx = ST_WAIT;
      ST_WAIT: begin
        if (hs)
          state_nx = ST_ACCUM;
        else if (wd_expired)
          state_nx = ST_ERR;
      end
      ST_ACCUM:  state_nx = (count == LAST_IDX) ? ST_SETTLE : ST_WAIT;
      ST_SETTLE: if (settle_cnt == '0) state_nx = ST_DONE;
      ST_DONE:   if (start) state_nx = ST_INIT;
`ifdef LINREG_CTRL_TIMEOUT_EN
      ST_ERR:    if (start) state_nx = ST_INIT;
`endif
      default:   state_nx = ST_IDLE;
    endcase
    if (abort)
      state_nx = ST_IDLE;
  end

  always_comb begin
    in_ready  = 1'b0;
    ldx       = 1'b0;
    ldy       = 1'b0;
    initsumx  = 1'b0;
    initsumy  = 1'b0;
    initsumxx = 1'b0;
    initsumxy = 1'b0;
    ldsumx    = 1'b0;
    ldsumy    = 1'b0;
    ldsumxx   = 1'b0;
    ldsumxy   = 1'b0;
    en        = 1'b0;
    busy      = 1'b0;
    err       = 1'b0;
    case (state)
      ST_INIT: begin
        initsumx  = 1'b1;
        initsumy  = 1'b1;
        initsumxx = 1'b1;
        initsumxy = 1'b1;
        busy      = 1'b1;
      end
      ST_WAIT: begin
        in_ready = 1'b1;
        ldx      = in_valid;
        ldy      = in_valid;
        busy     = 1'b1;
      end
      ST_ACCUM: begin
        ldsumx  = 1'b1;
        ldsumy  = 1'b1;
        ldsumxx = 1'b1;
        ldsumxy = 1'b1;
        busy    = 1'b1;
      end
      ST_SETTLE: busy = 1'b1;
      ST_DONE:   en   = 1'b1;
`ifdef LINREG_CTRL_TIMEOUT_EN
      ST_ERR:    err  = 1'b1;
`endif
      default: ;
    endcase
  end

  // Clearing on entry to INIT/IDLE makes count read 0 during INIT and right after abort.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      count <= '0;
    else if ((state_nx == ST_INIT) || (state_nx == ST_IDLE))
      count <= '0;
    else if (state == ST_ACCUM)
      count <= count + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      settle_cnt <= SETTLE_LOAD;
    else if (state == ST_SETTLE)
      settle_cnt <= settle_cnt - SET_W'(1);
    else
      settle_cnt <= SETTLE_LOAD;
  end

endmodule

// File: tb/tb_linreg_ctrl.sv
// Scoreboard bench for linreg_ctrl: a timeline model pushes expected strobe events, a monitor pops them.
// Define LINREG_CTRL_TIMEOUT_EN to also exercise the watchdog.
module tb_linreg_ctrl;

  localparam int N = 4;
  localparam int S = 2;
  localparam int T = 8;
  localparam int CW = 9;

  localparam int EV_INIT = 0;
  localparam int EV_LDX  = 1;
  localparam int EV_SUM  = 2;
  localparam int EV_EN   = 3;

  localparam int M_NORM  = 0;
  localparam int M_ABORT = 1;
  localparam int M_RST   = 2;

  typedef struct {
    int kind;
    int cyc;
    int cnt;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready, ldx, ldy;
  logic initsumx, initsumy, initsumxx, initsumxy;
  logic ldsumx, ldsumy, ldsumxx, ldsumxy;
  logic [CW-1:0] count;
  logic en, busy, err;

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  ev_t exp_q[$];
  ev_t plan_q[$];
  int acc_q[$];
  bit vq[$];
  logic en_prev = 1'b0;

  linreg_ctrl #(
    .N_SAMPLES(N), .CNT_W(CW), .SETTLE_CYCLES(S), .TIMEOUT_CYCLES(T)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .in_valid(in_valid), .in_ready(in_ready), .ldx(ldx), .ldy(ldy),
    .initsumx(initsumx), .initsumy(initsumy), .initsumxx(initsumxx), .initsumxy(initsumxy),
    .ldsumx(ldsumx), .ldsumy(ldsumy), .ldsumxx(ldsumxx), .ldsumxy(ldsumxy),
    .count(count), .en(en), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic ev_t mk(input int k, input int c, input int n);
    ev_t e;
    e.kind = k;
    e.cyc  = c;
    e.cnt  = n;
    return e;
  endfunction

  // in_valid offered in cycle c of a run whose start was sampled at edge e
  function automatic bit vat(input int c, input int e);
    int i;
    i = c - (e + 1);
    if (i >= 0 && i < vq.size())
      return vq[i];
    return 1'b1;
  endfunction

  // Timeline from the rules: INIT at e, each sample waits for the first valid cycle at or
  // after the next WAIT opportunity, accumulates one cycle later, then S settle cycles.
  task automatic plan(input int e, output int en_c);
    int t, c;
    plan_q.delete();
    acc_q.delete();
    plan_q.push_back(mk(EV_INIT, e, 0));
    t = e + 1;
    for (int k = 0; k < N; k++) begin
      c = t;
      while (!vat(c, e)) c++;
      plan_q.push_back(mk(EV_LDX, c, k));
      plan_q.push_back(mk(EV_SUM, c + 1, k));
      acc_q.push_back(c + 1);
      t = c + 2;
    end
    en_c = t + S;
    plan_q.push_back(mk(EV_EN, en_c, N));
  endtask

  task automatic do_run(input bit noise, input int mode, output int en_c);
    int e, a;
    e = cyc + 1;
    plan(e, en_c);
    a = en_c;
    if (mode == M_ABORT) a = acc_q[N-1] + 1 + int'($urandom_range(0, S - 1));
    if (mode == M_RST)   a = acc_q[$urandom_range(0, N - 1)];
    foreach (plan_q[i])
      if (mode == M_NORM || (mode == M_ABORT && plan_q[i].cyc <= a) ||
          (mode == M_RST && plan_q[i].cyc < a))
        exp_q.push_back(plan_q[i]);
    start = 1'b1;
    in_valid = 1'b0;
    for (int c = e; c <= a; c++) begin
      tick();
      start = noise && (c < en_c) && (c != a) && ($urandom_range(0, 2) == 0);
      in_valid = vat(c, e);
      abort = (mode == M_ABORT) && (c == a);
      if (mode == M_RST && c == a) begin
        chk("in_accum_before_rst", ldsumx, 1);
        #2 rst = 1'b1;
        #1 chk("async_rst_outputs", {in_ready, ldx, ldy, initsumx, initsumy, initsumxx, initsumxy,
                                     ldsumx, ldsumy, ldsumxx, ldsumxy, en, busy, err, count}, 0);
      end
    end
    if (mode == M_ABORT) begin
      tick();
      abort = 1'b0;
      chk("abort_idle", {en, busy, count}, 0);
      for (int i = 0; i < 6; i++) begin
        tick();
        in_valid = $urandom_range(0, 1);
      end
      chk("abort_stays_idle", {en, busy}, 0);
    end
    if (mode == M_RST) begin
      tick();
      rst = 1'b0;
      tick();
      chk("rst_idle", {busy, count}, 0);
    end
  endtask

  // Monitor: every strobe group event must match the head of the expected queue.
  always @(negedge clk) begin
    int kind;
    ev_t ev;
    if (rst) begin
      en_prev = 1'b0;
    end else begin
      checks++;
      if (ldx !== ldy || ldx !== (in_valid & in_ready) ||
          !({initsumx, initsumy, initsumxx, initsumxy} inside {4'h0, 4'hf}) ||
          !({ldsumx, ldsumy, ldsumxx, ldsumxy} inside {4'h0, 4'hf})) begin
        errors++;
        $display("FAIL strobe_rule ldx=%0b ldy=%0b rdy=%0b vld=%0b init=%b sum=%b (cycle %0d)",
                 ldx, ldy, in_ready, in_valid, {initsumx, initsumy, initsumxx, initsumxy},
                 {ldsumx, ldsumy, ldsumxx, ldsumxy}, cyc);
      end
      kind = -1;
      if (initsumx)           kind = EV_INIT;
      else if (ldx)           kind = EV_LDX;
      else if (ldsumx)        kind = EV_SUM;
      else if (en && !en_prev) kind = EV_EN;
      if (kind >= 0) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event kind=%0d count=%0d at cycle %0d", kind, count, cyc);
        end else begin
          ev = exp_q.pop_front();
          if (ev.kind != kind || ev.cyc != cyc || ev.cnt != int'(count)) begin
            errors++;
            $display("FAIL event actual kind=%0d cyc=%0d count=%0d required kind=%0d cyc=%0d count=%0d",
                     kind, cyc, count, ev.kind, ev.cyc, ev.cnt);
          end
        end
      end
      en_prev = en;
    end
  end

  initial begin
    int en_c;
    int e;
    repeat (3) @(posedge clk);
    #1 chk("reset_outputs", {in_ready, ldx, ldy, initsumx, initsumy, initsumxx, initsumxy,
                             ldsumx, ldsumy, ldsumxx, ldsumxy, en, busy, err, count}, 0);
    rst = 1'b0;
    tick();
    tick();

    // nominal, then back-to-back from DONE with start noise while busy
    vq.delete();
    do_run(1'b0, M_NORM, en_c);
    chk("done_count", count, N);
    chk("done_en", en, 1);
    do_run(1'b1, M_NORM, en_c);

    // backpressure: valid dropped 5 cycles after the 2nd sample
    vq = '{1, 1, 1, 1, 0, 0, 0, 0, 0};
    do_run(1'b0, M_NORM, en_c);

    repeat (6) begin
      vq.delete();
      for (int i = 0; i < 24; i++) vq.push_back($urandom_range(0, 3) != 0);
      do_run(1'b1, M_NORM, en_c);
    end

    vq.delete();
    do_run(1'b0, M_ABORT, en_c);
    do_run(1'b0, M_NORM, en_c);

    // abort and start together from IDLE: abort wins
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tick();
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    chk("abort_beats_start", busy, 0);
    tick();

    vq.delete();
    for (int i = 0; i < 16; i++) vq.push_back($urandom_range(0, 1));
    do_run(1'b0, M_RST, en_c);
    vq.delete();
    do_run(1'b0, M_NORM, en_c);

`ifdef LINREG_CTRL_TIMEOUT_EN
    e = cyc + 1;
    exp_q.push_back(mk(EV_INIT, e, 0));
    start = 1'b1;
    in_valid = 1'b0;
    tick();
    start = 1'b0;
    for (int c = e + 1; c <= e + T + 1; c++) begin
      tick();
      if (c == e + T) chk("err_before_timeout", err, 0);
    end
    chk("err_after_timeout", {err, busy}, 2'b10);
    vq.delete();
    do_run(1'b0, M_NORM, en_c);
    chk("err_cleared", err, 0);
`else
    e = 0;
    chk("err_tied_low", err, 0);
`endif

    repeat (3) tick();
    chk("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
